// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, requester ids and default widths.
package arb_types;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } arb_req_t;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection between I-cache and D-cache requests.
// ARB_ROUND_ROBIN_EN selects round-robin tie breaking; otherwise D-cache wins ties.
module arb_pick
  import arb_types::*;
(
  input  logic     i_req,
  input  logic     d_req,
  input  arb_req_t last_grant,
  output logic     valid,
  output arb_req_t winner
);

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant names the requester favoured on the next tie.
  always_comb begin
    valid  = i_req | d_req;
    winner = REQ_D;
    if (i_req && !d_req)
      winner = REQ_I;
    else if (i_req && d_req)
      winner = last_grant;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    valid  = i_req | d_req;
    winner = REQ_D;
    if (i_req && !d_req)
      winner = REQ_I;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between I-cache and D-cache miss/writeback traffic.
// Optional round-robin tie breaking via ARB_ROUND_ROBIN_EN (see arb_pick).
module mem_port_arbiter
  import arb_types::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              busy
);

  arb_state_t        state, state_nxt;
  arb_req_t          owner_q, rr_ptr, pick_winner;
  logic              pick_valid, op_wr_q, granted;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q, i_line_q, d_line_q;

  arb_pick u_pick (
    .i_req      (i_read),
    .d_req      (d_read | d_write),
    .last_grant (rr_ptr),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:             if (pick_valid) state_nxt = (pick_winner == REQ_I) ? GRANT_I : GRANT_D;
      GRANT_I, GRANT_D: if (mem_resp) state_nxt = DONE;
      DONE:             state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request inputs are only looked at in IDLE; everything downstream runs off these latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= REQ_D;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      i_line_q <= '0;
      d_line_q <= '0;
      rr_ptr   <= REQ_D;
    end else begin
      if (state == IDLE && pick_valid) begin
        owner_q <= pick_winner;
        if (pick_winner == REQ_I) begin
          addr_q  <= i_addr;
          op_wr_q <= 1'b0;
        end else begin
          addr_q  <= d_addr;
          op_wr_q <= d_write;
          if (d_write) wdata_q <= d_wdata;
        end
      end
      if (granted && mem_resp) begin
        if (!op_wr_q) begin
          if (owner_q == REQ_I) i_line_q <= mem_rdata;
          else                  d_line_q <= mem_rdata;
        end
        rr_ptr <= (owner_q == REQ_I) ? REQ_D : REQ_I;
      end
    end
  end

  // Outputs decode straight from the state register so an async reset drops them at once.
  assign granted   = (state == GRANT_I) || (state == GRANT_D);
  assign mem_read  = granted && !op_wr_q;
  assign mem_write = granted && op_wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);
  assign i_resp    = (state == DONE) && (owner_q == REQ_I);
  assign d_resp    = (state == DONE) && (owner_q == REQ_D);
  assign i_rdata   = i_line_q;
  assign d_rdata   = d_line_q;

`ifndef SYNTHESIS
  d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write));
`endif

endmodule
